// File: rtl/bmaxpool_pkg.sv
// rtl/bmaxpool_pkg.sv - shared types and constants for the binary max-pool sequencer
package bmaxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW_A = 2'd1,
    ROW_B = 2'd2,
    EMIT  = 2'd3
  } bmp_state_t;

  // Pooling window edge: each output bit covers POOL_W columns of POOL_W rows.
  localparam int POOL_W = 2;

endpackage

// File: rtl/bmaxpool_row_or.sv
// rtl/bmaxpool_row_or.sv - combinational 2x2 OR reduction of a row pair
module bmaxpool_row_or
  import bmaxpool_pkg::*;
#(
  parameter int O_SIZE = 13
) (
  input  logic [POOL_W*O_SIZE-1:0] row_a,
  input  logic [POOL_W*O_SIZE-1:0] row_b,
  output logic [O_SIZE-1:0]        pooled
);

  for (genvar j = 0; j < O_SIZE; j++) begin : g_col
    assign pooled[j] = |{row_a[POOL_W*j +: POOL_W], row_b[POOL_W*j +: POOL_W]};
  end

endmodule

// File: rtl/bmaxpool_seq.sv
// rtl/bmaxpool_seq.sv - row-pair sequencer for binary 2x2 max-pool; stall counter under BMAXPOOL_SEQ_STALL_CNT_EN
module bmaxpool_seq #(
  parameter int I_SIZE  = 26,
  parameter int O_SIZE  = 13,
  parameter int STALL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [I_SIZE-1:0]          in_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [O_SIZE-1:0]          out_row,
  output logic [$clog2(O_SIZE)-1:0]  out_idx,
  output logic                       frame_done,
  output logic [STALL_W-1:0]         stall_cnt
);
  import bmaxpool_pkg::*;

  localparam int IDX_W = $clog2(O_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(O_SIZE - 1);

  if (I_SIZE != POOL_W * O_SIZE) begin : g_size_check
    $error("bmaxpool_seq: I_SIZE must equal 2*O_SIZE");
  end

  bmp_state_t          state;
  logic [I_SIZE-1:0]   row_buf;
  logic [O_SIZE-1:0]   pooled;
  logic                in_fire;
  logic                out_fire;
  logic                start_fire;

  assign busy     = (state != IDLE);
  assign in_ready = (state == ROW_A) || (state == ROW_B);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // A start landing on the frame_done cycle is dropped so the source must re-pulse.
  assign start_fire = start && (state == IDLE) && !frame_done;

  bmaxpool_row_or #(
    .O_SIZE (O_SIZE)
  ) u_row_or (
    .row_a  (row_buf),
    .row_b  (in_row),
    .pooled (pooled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row_buf    <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fire) begin
            out_idx <= '0;
            state   <= ROW_A;
          end
        end
        ROW_A: begin
          if (in_fire) begin
            row_buf <= in_row;
            state   <= ROW_B;
          end
        end
        ROW_B: begin
          if (in_fire) begin
            out_row   <= pooled;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            if (out_idx == LAST_IDX) begin
              frame_done <= 1'b1;
              out_idx    <= '0;
              state      <= IDLE;
            end else begin
              out_idx <= out_idx + 1'b1;
              state   <= ROW_A;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BMAXPOOL_SEQ_STALL_CNT_EN
  // Saturating count of back-pressured output cycles; survives frame_done until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_fire) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
